ppc_fetch_queue: RTL and testbench
==================================

// Module: ppc_fetch_queue
// PURPOSE
//  Instruction fetch stage feeding the single-cycle PPC execute core.
//  Reads 64-bit big-endian doublewords from the instruction memory port and splits them into 32-bit words.
//  Buffers the words with their PCs in a small FIFO and presents them to decode over valid/ready.
//  Execute flushes the stage and restarts fetch on a taken branch through the redirect port.
// PARAMETERS
//  DEPTH     4   queue entries; power of 2, >= 2
//  RESET_PC  0   64-bit fetch address loaded at reset
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  mem_req      out  1   fetch request valid
//  mem_addr     out  61  [0:60] doubleword address (= fetch_pc[0:60])
//  mem_gnt      in   1   request accepted this cycle (mem_req & mem_gnt)
//  mem_rvalid   in   1   response valid, in order, one per accepted request, >= 1 cycle after gnt
//  mem_rdata    in   64  [0:63] doubleword; [0:31] at addr+0, [32:63] at addr+4
//  redirect     in   1   taken branch: flush, restart at redirect_pc
//  redirect_pc  in   64  new fetch PC; bits [62:63] ignored (treated as 0)
//  inst_valid   out  1   head entry valid
//  inst         out  32  [0:31] head instruction word
//  inst_pc      out  64  [0:63] PC of head instruction
//  inst_ready   in   1   decode consumes head when inst_valid & inst_ready
// BEHAVIOUR
//  - Reset: state IDLE, fetch_pc=RESET_PC, queue empty; inst_valid=0, inst=0, inst_pc=0.
//  - While rst is high, mem_req=0.
//  - FSM, at most one outstanding request:
//    IDLE:  mem_req = (free >= 2) & ~redirect, where free = DEPTH - count (registered count).
//           If mem_req & mem_gnt -> WAIT.
//    WAIT:  mem_req=0. On mem_rvalid, enqueue data and advance fetch_pc -> IDLE.
//    DRAIN: mem_req=0. On mem_rvalid, discard data -> IDLE.
//  - mem_addr is held stable while mem_req is high and mem_gnt is low.
//  - Enqueue on rvalid:
//    - fetch_pc[61]=0: push {fetch_pc, rdata[0:31]}, then {fetch_pc+4, rdata[32:63]}.
//    - fetch_pc[61]=1: push only {fetch_pc, rdata[32:63]}.
//    - Then fetch_pc <= {fetch_pc[0:60]+1, 3'b000}; wraps modulo 2^64.
//  - Queue: circular buffer with head/tail pointers and a count of width clog2(DEPTH)+1.
//    - In one cycle: up to 2 pushes and 1 pop; push and pop in the same cycle are legal.
//    - inst_valid = (count != 0). inst and inst_pc come from the head entry; they are stable while inst_ready is low.
//    - The free >= 2 issue rule guarantees no overflow; overflow is an assertion failure.
//  - Redirect (highest priority, evaluated in the same cycle):
//    - Queue emptied next cycle; a same-cycle pop or push is discarded.
//    - fetch_pc <= {redirect_pc[0:61], 2'b00}.
//    - IDLE or DRAIN -> IDLE (DRAIN stays DRAIN if no rvalid this cycle).
//    - WAIT with mem_rvalid=1 -> IDLE, data dropped.
//    - WAIT with mem_rvalid=0 -> DRAIN.
//    - Back-to-back redirects: the last redirect_pc wins.
//  - Latency: redirect at cycle N gives mem_req at N+1.
//    With gnt at N+1 and rvalid at N+2, inst_valid rises at N+3.
//  - Throughput: up to 2 instructions per request; steady state 1 per cycle with 1-cycle memory.
//  - rst overrides redirect and every handshake; reset mid-WAIT drops the in-flight response.
//    The memory must not return rvalid for a request whose grant preceded reset.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output ports stall_cnt (32) and flush_cnt (32), both 0 on rst.
//   - stall_cnt += 1 each cycle with inst_valid=0 and no redirect.
//   - flush_cnt += 1 each cycle with redirect=1.
//   - Both saturate at 32'hFFFFFFFF.
//  FETCH_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  1. Reset, RESET_PC=0, 1-cycle mem, mem[0]=64'h38000001_38600041, inst_ready=1.
//     -> mem_addr=0; inst 0x38000001 @pc0, then 0x38600041 @pc4 on consecutive cycles.
//  2. redirect_pc=0x0C, mem[1]=64'hAAAAAAAA_BBBBBBBB.
//     -> mem_addr=1; only 0xBBBBBBBB @0x0C queued; next mem_addr=2.
//  3. inst_ready=0 with DEPTH=4 and 1-cycle mem.
//     -> count reaches 4, no mem_req at free<2; inst/inst_pc stable until inst_ready=1.
//  4. 3-cycle mem latency; redirect to 0x40 one cycle after gnt.
//     -> in-flight response discarded (DRAIN); next mem_addr=8; first inst_pc=0x40.
//  5. redirect coincident with mem_rvalid and a pop.
//     -> no push, queue empty next cycle, inst_valid=0.
//  6. rst asserted while in WAIT.
//     -> next cycle IDLE, inst_valid=0, mem_addr=RESET_PC[0:60].
//     With FETCH_PERF_EN: stall_cnt and flush_cnt read 0.

Source files
------------

// File: rtl/ppc_fetch_queue.sv
// Fetch stage: issues doubleword reads, splits them into 32-bit words and queues them with their PCs for decode.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module ppc_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [60:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  fetchState_t state;
  logic [63:0] fetchPc;

  logic [31:0] wordMem [DEPTH];
  logic [63:0] pcMem   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tailPlusOne;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] freeSlots;

  logic        canIssue;
  logic        accept;
  logic        pushEn;
  logic        pushTwo;
  logic        popEn;
  logic [1:0]  numPush;
  logic [31:0] firstWord;
  logic [63:0] secondPc;
  logic [63:0] nextFetchPc;
  logic        overflow;
  logic [1:0]  unusedRedirectLow;

  assign unusedRedirectLow = redirect_pc[1:0];

  // Only issue when two slots are free, so a full doubleword always fits on return.
  assign freeSlots = CNT_W'(DEPTH) - count;
  assign canIssue  = (freeSlots >= CNT_W'(2));
  assign mem_req   = ~rst & (state == IDLE) & canIssue & ~redirect;
  assign mem_addr  = fetchPc[63:3];
  assign accept    = mem_req & mem_gnt;

  assign pushEn      = (state == WAIT) & mem_rvalid & ~redirect;
  assign pushTwo     = pushEn & ~fetchPc[2];
  assign numPush     = pushEn ? (fetchPc[2] ? 2'd1 : 2'd2) : 2'd0;
  assign popEn       = inst_valid & inst_ready & ~redirect;
  assign firstWord   = fetchPc[2] ? mem_rdata[31:0] : mem_rdata[63:32];
  assign secondPc    = fetchPc + 64'd4;
  assign nextFetchPc = {fetchPc[63:3] + 61'd1, 3'b000};
  assign tailPlusOne = tail + PTR_W'(1);

  assign overflow = ({1'b0, count} + (CNT_W + 1)'(numPush))
                    > ((CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(popEn));

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? wordMem[head] : 32'h0;
  assign inst_pc    = inst_valid ? pcMem[head] : 64'h0;

  // Fetch sequencer: one request in flight; a redirect with a response still pending goes to DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
    end else if (redirect) begin
      fetchPc <= {redirect_pc[63:2], 2'b00};
      case (state)
        IDLE:    state <= IDLE;
        WAIT:    state <= mem_rvalid ? IDLE : DRAIN;
        DRAIN:   state <= mem_rvalid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            fetchPc <= nextFetchPc;
            state   <= IDLE;
          end
        end
        DRAIN: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      wordMem[tail] <= firstWord;
      pcMem[tail]   <= fetchPc;
      if (pushTwo) begin
        wordMem[tailPlusOne] <= mem_rdata[31:0];
        pcMem[tailPlusOne]   <= secondPc;
      end
    end
  end

  // Queue pointers: a redirect empties the queue and discards any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(numPush);
      head  <= head + PTR_W'(popEn);
      count <= count + CNT_W'(numPush) - CNT_W'(popEn);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect) begin
      assert (!overflow);
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters for cycles starved of instructions and cycles spent redirecting.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (!inst_valid && !redirect && stall_cnt != 32'hFFFFFFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (redirect && flush_cnt != 32'hFFFFFFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Directed bench for ppc_fetch_queue: a per-cycle vector table plus hand sequences for
// backpressure, drain, redirect collisions and mid-request reset.
module tb_ppc_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [60:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'h0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b1;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int total = 0;
  int bad = 0;
  int memLatency = 1;

  logic        respPending = 1'b0;
  int          respTimer = 0;
  logic [60:0] respAddr = '0;

  always #5 clk = ~clk;

  ppc_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [63:0] memWord(input logic [60:0] a);
    if (a == 61'd0) return 64'h38000001_38600041;
    if (a == 61'd1) return 64'hAAAAAAAA_BBBBBBBB;
    return {8'hC0, a[23:0], 8'hD0, a[23:0]};
  endfunction

  function automatic logic [31:0] expWord(input logic [63:0] pc);
    logic [63:0] dw;
    dw = memWord(pc[63:3]);
    return pc[2] ? dw[31:0] : dw[63:32];
  endfunction

  // Memory model: captures the grant at the falling edge and answers memLatency cycles later.
  always @(negedge clk) begin
    if (rst) begin
      respPending = 1'b0;
    end else if (mem_req && mem_gnt) begin
      respPending = 1'b1;
      respTimer   = memLatency;
      respAddr    = mem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (respPending) begin
      respTimer = respTimer - 1;
      if (respTimer == 0) begin
        mem_rvalid  = 1'b1;
        mem_rdata   = memWord(respAddr);
        respPending = 1'b0;
      end
    end
  end

  typedef struct {
    logic        redirect;
    logic [63:0] redirectPc;
    logic        ready;
    logic        expReq;
    logic [60:0] expAddr;
    logic        expValid;
    logic [31:0] expInst;
    logic [63:0] expPc;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [63:0] pc, input logic ready);
    redirect    = redir;
    redirect_pc = pc;
    inst_ready  = ready;
  endtask

  task automatic applyReset(input int lat);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b1);
    memLatency = lat;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles);
    int n;
    n = 0;
    while (inst_valid !== 1'b1 && n < maxCycles) begin
      nextCycle();
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 64'h0,  1'b1, 1'b1, 61'd0, 1'b0, 32'h0,        64'h0};
    vecs[1] = '{1'b0, 64'h0,  1'b1, 1'b0, 61'd0, 1'b0, 32'h0,        64'h0};
    vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b1, 61'd1, 1'b1, 32'h38000001, 64'h0};
    vecs[3] = '{1'b0, 64'h0,  1'b1, 1'b0, 61'd1, 1'b1, 32'h38600041, 64'h4};
    vecs[4] = '{1'b1, 64'hC,  1'b1, 1'b0, 61'd2, 1'b1, 32'hAAAAAAAA, 64'h8};
    vecs[5] = '{1'b0, 64'h0,  1'b1, 1'b1, 61'd1, 1'b0, 32'h0,        64'h0};
    vecs[6] = '{1'b0, 64'h0,  1'b1, 1'b0, 61'd1, 1'b0, 32'h0,        64'h0};
    vecs[7] = '{1'b0, 64'h0,  1'b1, 1'b1, 61'd2, 1'b1, 32'hBBBBBBBB, 64'hC};
    vecs[8] = '{1'b0, 64'h0,  1'b1, 1'b0, 61'd2, 1'b0, 32'h0,        64'h0};
    vecs[9] = '{1'b0, 64'h0,  1'b1, 1'b1, 61'd3, 1'b1, 32'hC0000002, 64'h10};

    // Table: reset fetch from 0, then a redirect to an odd word address.
    applyReset(1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nextCycle();
      applyStimulus(vecs[i].redirect, vecs[i].redirectPc, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("v%0d.req", i),   64'(mem_req),    64'(vecs[i].expReq));
      checkOutput($sformatf("v%0d.addr", i),  64'(mem_addr),   64'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d.valid", i), 64'(inst_valid), 64'(vecs[i].expValid));
      checkOutput($sformatf("v%0d.inst", i),  64'(inst),       64'(vecs[i].expInst));
      checkOutput($sformatf("v%0d.pc", i),    inst_pc,         vecs[i].expPc);
    end

    // Backpressure: queue fills, issue stops, head holds, then drains in order.
    applyReset(1);
    inst_ready = 1'b0;
    repeat (4) nextCycle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d.req", i),   64'(mem_req),    64'd0);
      checkOutput($sformatf("bp%0d.valid", i), 64'(inst_valid), 64'd1);
      checkOutput($sformatf("bp%0d.inst", i),  64'(inst),       64'h38000001);
      checkOutput($sformatf("bp%0d.pc", i),    inst_pc,         64'h0);
      nextCycle();
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("dr%0d.valid", i), 64'(inst_valid), 64'd1);
      checkOutput($sformatf("dr%0d.pc", i),    inst_pc,         64'(4 * i));
      checkOutput($sformatf("dr%0d.inst", i),  64'(inst),       64'(expWord(64'(4 * i))));
      if (i == 1) checkOutput("dr1.reqFree1", 64'(mem_req), 64'd0);
      if (i == 2) checkOutput("dr2.reqFree2", 64'(mem_req), 64'd1);
      nextCycle();
    end

    // Redirect one cycle after grant with 3-cycle memory: response must be drained.
    applyReset(3);
    @(negedge clk);
    checkOutput("dn.req0", 64'(mem_req), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 64'h40, 1'b1);
    @(negedge clk);
    checkOutput("dn.req1", 64'(mem_req), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("dn.reqDrain", 64'(mem_req), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("dn.validDrop", 64'(inst_valid), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("dn.validIdle", 64'(inst_valid), 64'd0);
    checkOutput("dn.reqIdle",   64'(mem_req),    64'd1);
    checkOutput("dn.addrIdle",  64'(mem_addr),   64'd8);
    waitValid(20);
    checkOutput("dn.valid", 64'(inst_valid), 64'd1);
    checkOutput("dn.pc",    inst_pc,         64'h40);
    checkOutput("dn.inst",  64'(inst),       64'hC0000008);

    // Redirect coincident with a response and a pop: nothing is kept.
    applyReset(1);
    repeat (3) nextCycle();
    applyStimulus(1'b1, 64'h100, 1'b1);
    @(negedge clk);
    checkOutput("co.validBefore", 64'(inst_valid), 64'd1);
    checkOutput("co.rvalid",      64'(mem_rvalid), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("co.validAfter", 64'(inst_valid), 64'd0);
    checkOutput("co.req",        64'(mem_req),    64'd1);
    checkOutput("co.addr",       64'(mem_addr),   64'h20);
    nextCycle();
    @(negedge clk);
    checkOutput("co.validWait", 64'(inst_valid), 64'd0);
    waitValid(20);
    checkOutput("co.valid", 64'(inst_valid), 64'd1);
    checkOutput("co.pc",    inst_pc,         64'h100);
    checkOutput("co.inst",  64'(inst),       64'hC0000020);

    // Reset while a request is outstanding.
    applyReset(3);
    applyStimulus(1'b1, 64'h200, 1'b1);
    @(negedge clk);
    checkOutput("rs.reqRedir", 64'(mem_req), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("rs.req",  64'(mem_req),  64'd1);
    checkOutput("rs.addr", 64'(mem_addr), 64'h40);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rs.reqInRst", 64'(mem_req), 64'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rs.validAfter", 64'(inst_valid), 64'd0);
    checkOutput("rs.reqAfter",   64'(mem_req),    64'd1);
    checkOutput("rs.addrAfter",  64'(mem_addr),   64'd0);
`ifdef FETCH_PERF_EN
    checkOutput("rs.stallCnt", 64'(stall_cnt), 64'd0);
    checkOutput("rs.flushCnt", 64'(flush_cnt), 64'd0);
`endif
    waitValid(20);
    checkOutput("rs.valid", 64'(inst_valid), 64'd1);
    checkOutput("rs.pc",    inst_pc,         64'h0);
    checkOutput("rs.inst",  64'(inst),       64'h38000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
